// File: rtl/fp_div_pkg.sv
// Shared types and constants for the iterative binary32 divider.
// The special-operand class is resolved at accept time and carried through the iteration.
package fp_div_pkg;
  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int ITERS = MAN_W + 3;
  localparam int Q_W   = MAN_W + 3;
  localparam int CNT_W = $clog2(ITERS + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_EXC, SP_DBZ, SP_ZERO} special_t;

  // Priority order: all-ones exponent, then x/0, then 0/x (zero exponent flushes to zero).
  function automatic special_t classify(input logic [EXP_W-1:0] ea, input logic [EXP_W-1:0] eb);
    if (ea == EXP_MAX || eb == EXP_MAX) return SP_EXC;
    else if (eb == '0 && ea != '0)     return SP_DBZ;
    else if (ea == '0)                 return SP_ZERO;
    else                               return SP_NONE;
  endfunction
endpackage

// File: rtl/fp_div_round_pack.sv
// Combinational normalise/round/pack of the raw quotient into a binary32 result and flags.
module fp_div_round_pack
  import fp_div_pkg::*;
(
  input  logic [Q_W-1:0]   q,
  input  logic             rem_nz,
  input  logic [EXP_W-1:0] ea,
  input  logic [EXP_W-1:0] eb,
  input  logic             sign,
  input  special_t         sp,
  output logic [FP_W-1:0]  result,
  output logic             exception,
  output logic             overflow,
  output logic             underflow,
  output logic             div_by_zero
);
  localparam logic signed [9:0] E_BIAS = 10'(BIAS);

  logic [MAN_W-1:0] mant;
  logic             guard;
  logic             sticky;
  logic [MAN_W:0]   mant_sum;
  logic signed [9:0] e_pre;
  logic signed [9:0] e_fin;

  always_comb begin
    // Quotient lies in (0.5, 2): the top bit tells whether a one-place normalising shift is needed.
    if (q[Q_W-1]) begin
      mant   = q[Q_W-2:2];
      guard  = q[1];
      sticky = q[0] | rem_nz;
      e_pre  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS;
    end else begin
      mant   = q[Q_W-3:1];
      guard  = q[0];
      sticky = rem_nz;
      e_pre  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS - 10'sd1;
    end
    mant_sum = {1'b0, mant} + {{MAN_W{1'b0}}, guard & sticky};
    e_fin    = mant_sum[MAN_W] ? e_pre + 10'sd1 : e_pre;

    result      = {sign, 31'd0};
    exception   = 1'b0;
    overflow    = 1'b0;
    underflow   = 1'b0;
    div_by_zero = 1'b0;
    if (sp == SP_EXC) begin
      exception = 1'b1;
    end else if (sp == SP_DBZ) begin
      result      = {sign, EXP_MAX, {MAN_W{1'b0}}};
      div_by_zero = 1'b1;
    end else if (sp == SP_ZERO) begin
      result = {sign, 31'd0};
    end else if (e_fin >= 10'sd255) begin
      result   = {sign, EXP_MAX, {MAN_W{1'b0}}};
      overflow = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      underflow = 1'b1;
    end else begin
      result = {sign, e_fin[EXP_W-1:0], mant_sum[MAN_W-1:0]};
    end
  end
endmodule

// File: rtl/fp_div_iter.sv
// Iterative binary32 divider: restoring radix-2 mantissa division, one quotient bit per cycle,
// with valid/ready handshakes and a fixed latency regardless of operand class.
module fp_div_iter
  import fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        exception,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);
  state_t           state;
  logic             sign_reg;
  logic [EXP_W-1:0] ea_reg;
  logic [EXP_W-1:0] eb_reg;
  special_t         sp_reg;
  logic [MAN_W:0]   mb_reg;
  logic [Q_W-1:0]   r_reg;
  logic [Q_W-1:0]   q_reg;
  logic [CNT_W-1:0] iter_reg;

  logic             r_ge;
  logic [Q_W-1:0]   r_sub;
  logic [Q_W-1:0]   r_next;
  logic [Q_W-1:0]   q_next;

  logic [FP_W-1:0]  rp_result;
  logic             rp_exception;
  logic             rp_overflow;
  logic             rp_underflow;
  logic             rp_div_by_zero;

  assign in_ready = (state == IDLE) && !reset;

  // The partial remainder stays below the divisor after subtraction, so the shift never loses a set bit.
  assign r_ge   = r_reg >= {2'b00, mb_reg};
  assign r_sub  = r_ge ? r_reg - {2'b00, mb_reg} : r_reg;
  assign r_next = {r_sub[Q_W-2:0], 1'b0};
  assign q_next = {q_reg[Q_W-2:0], r_ge};

  fp_div_round_pack u_round_pack (
    .q           (q_reg),
    .rem_nz      (r_reg != '0),
    .ea          (ea_reg),
    .eb          (eb_reg),
    .sign        (sign_reg),
    .sp          (sp_reg),
    .result      (rp_result),
    .exception   (rp_exception),
    .overflow    (rp_overflow),
    .underflow   (rp_underflow),
    .div_by_zero (rp_div_by_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sign_reg    <= 1'b0;
      ea_reg      <= '0;
      eb_reg      <= '0;
      sp_reg      <= SP_NONE;
      mb_reg      <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      iter_reg    <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      exception   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_reg    <= a[31] ^ b[31];
            ea_reg      <= a[30:23];
            eb_reg      <= b[30:23];
            sp_reg      <= classify(a[30:23], b[30:23]);
            mb_reg      <= {|b[30:23], b[22:0]};
            r_reg       <= {2'b00, |a[30:23], a[22:0]};
            q_reg       <= '0;
            iter_reg    <= '0;
            result      <= '0;
            exception   <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            state       <= DIV;
          end
        end
        DIV: begin
          // After ITERS quotient cycles, one more cycle packs the registered quotient.
          if (iter_reg == CNT_W'(ITERS)) begin
            result      <= rp_result;
            exception   <= rp_exception;
            overflow    <= rp_overflow;
            underflow   <= rp_underflow;
            div_by_zero <= rp_div_by_zero;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            r_reg    <= r_next;
            q_reg    <= q_next;
            iter_reg <= iter_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
- Iterative single-precision (IEEE-754 binary32 layout) floating-point divider. It is the inverse-operation companion to the team's 2-stage pipelined FP multiplier.
- Uses a restoring radix-2 mantissa divider, one quotient bit per cycle.
- Valid/ready handshake on input and output.
- Flag and special-value semantics match the multiplier, so the two can share result checkers.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa width (quotient iterations = MAN_W+3 = 26)
BIAS, 127, exponent bias

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  operands valid
in_ready  out  1  divider can accept operands
a  in  32  dividend
b  in  32  divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  32  quotient
exception  out  1  either operand exponent all-ones
overflow  out  1  result exponent too large
underflow  out  1  result exponent too small
div_by_zero  out  1  finite nonzero a divided by zero b

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high, on ports clk and reset.
  - Reset forces state IDLE and clears out_valid, result, exception, overflow, underflow, div_by_zero and all internal registers to 0.
  - in_ready = (state==IDLE) && !reset.
- States: IDLE, DIV, DONE.
  - IDLE: on in_valid && in_ready, latch sign=a[31]^b[31], the exponent fields, and 24-bit mantissas. Hidden bit = |exp; exp==0 is treated as zero (flush). Classify specials, clear the iteration counter, go to DIV.
  - DIV: 26 cycles, one quotient bit per cycle. Quotient Q = floor(ma·2^25 / mb), remainder kept. The iteration always runs, giving a fixed latency, including for special operands.
    - On the last iteration, register the packed result and flags, set out_valid=1 and go to DONE.
  - DONE: result and flags are held stable while out_valid && !out_ready. On out_ready, clear out_valid and go to IDLE. No new operand is accepted in the same cycle.
- Latency: the accept edge is cycle 0; out_valid is first high after edge 27, i.e. visible 28 cycles after accept. Throughput is one operation per ≥29 cycles.
- Normalise and round (10-bit signed exponent arithmetic):
  - If Q[25]=1: mant=Q[24:2], guard=Q[1], sticky=Q[0]|(rem!=0), e = ea−eb+BIAS.
  - Else: mant=Q[23:1], guard=Q[0], sticky=(rem!=0), e = ea−eb+BIAS−1.
  - mant += guard & sticky, the same rounding rule as the multiplier. A carry out of the mantissa sets mant=0 and increments e.
- Result priority (first match wins):
  1. exception (ea or eb all-ones): result={sign,31'd0}, exception=1.
  2. b zero and a nonzero: result={sign,8'hFF,23'd0}, div_by_zero=1.
  3. a zero (including 0/0): result={sign,31'd0}, no flags.
  4. e≥255: result={sign,8'hFF,23'd0}, overflow=1.
  5. e≤0: result={sign,31'd0}, underflow=1.
  6. Otherwise: {sign, e[7:0], mant}.
- Flags are only meaningful while out_valid=1. They are cleared when the next operation is accepted.
- Reset mid-operation (DIV or DONE): the operation is aborted, out_valid is never raised for it, and in_ready=1 in the first cycle after reset deasserts.
- in_valid outside IDLE is ignored. The operands are not held by the producer after the handshake.

Decomposition:
- Package fp_div_pkg holds:
  - state enum {IDLE, DIV, DONE}
  - FP_W=32, EXP_W, MAN_W, BIAS
  - EXP_MAX=8'hFF, ITERS=MAN_W+3
  - the special-class typedef
- One sub-module, fp_div_round_pack. It is combinational: inputs Q, rem-nonzero, ea, eb, sign and the special class; outputs result and flags. The parent registers its outputs on the last DIV cycle.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0) -> result=0x40400000, all flags 0, out_valid exactly 28 cycles after accept.
- a=0x3F800000, b=0x40400000 (1/3) -> result=0x3EAAAAAB (guard=1, sticky=1 rounding up), flags 0.
- a=0x3F800000, b=0x00000000 -> result=0x7F800000, div_by_zero=1. Then a=0x7F800000, b=0x40000000 -> result=0x00000000, exception=1.
- a=0x7F000000, b=0x3E800000 -> result=0x7F800000, overflow=1. Then a=0x00800000, b=0x40000000 -> result=0x00000000, underflow=1.
- out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0 throughout. On out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- reset asserted at DIV iteration 10 for 1 cycle -> out_valid stays 0 and all outputs 0. A fresh 6.0/2.0 issued afterwards completes normally in 28 cycles.
